// File: rtl/serial_frame_receiver.sv
// Purpose: UART-style receiver: start 0, 8 data bits LSB first, even parity, stop 1.
// Latency: valid pulses M + 10*CPB + 1 clocks after the start-detect cycle (M = CPB/2).
// Backpressure: none; the serial line cannot be stalled, results hold until the next frame.
module serial_frame_receiver #(
  parameter int CPB = 4
) (
  input  logic       C,
  input  logic       R,
  input  logic       D,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int M = CPB / 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       par_bad;
  logic       stop_bit;
  logic       done;
  logic       sample;

  // Sample strobe: first sample at the start-bit midpoint, then every CPB clocks.
  always_comb begin
    sample = 1'b0;
    if (state == START) begin
      sample = (cnt == 8'(M - 1));
    end else if (state == DATA || state == PARITY || state == STOP) begin
      sample = (cnt == 8'(CPB - 1));
    end
  end

  // State register.
  always_ff @(posedge C) begin
    if (R) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic driven by the sample strobe and the line value.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!D) state_nxt = START;
      end
      START: begin
        if (sample) state_nxt = D ? IDLE : DATA;
      end
      DATA: begin
        if (sample && idx == 3'd7) state_nxt = PARITY;
      end
      PARITY: begin
        if (sample) state_nxt = STOP;
      end
      STOP: begin
        if (sample) state_nxt = D ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (D) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-period counter: held at zero when idle, restarts at every sample.
  always_ff @(posedge C) begin
    if (R) begin
      cnt <= 8'd0;
    end else if (state == IDLE || state == WAIT_HIGH || sample) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Datapath: shift in data bits, evaluate parity, capture the stop bit.
  // done marks the stop sample so results are published on the following clock.
  always_ff @(posedge C) begin
    if (R) begin
      idx      <= 3'd0;
      shreg    <= 8'd0;
      par_bad  <= 1'b0;
      stop_bit <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sample) begin
        case (state)
          DATA: begin
            shreg <= {D, shreg[7:1]};
            idx   <= idx + 3'd1;
          end
          PARITY: begin
            par_bad <= (^shreg) ^ D;
          end
          STOP: begin
            stop_bit <= D;
            done     <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Output registers: loaded only on frame completion, otherwise held.
  always_ff @(posedge C) begin
    if (R) begin
      data       <= 8'd0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
        data       <= shreg;
        parity_err <= par_bad;
        frame_err  <= ~stop_bit;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed frames plus randomized traffic,
// checked against expectations built from the frame contents and the
// start-detect cycle of each frame.
module tb_serial_frame_receiver;
  localparam int CPB = 4;
  localparam int M   = CPB / 2;
  localparam int LAT = M + 10 * CPB + 1;

  logic       C = 1'b0;
  logic       R;
  logic       D;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         obs_t[$];
  logic [7:0] obs_d[$];
  logic       obs_p[$];
  logic       obs_f[$];

  serial_frame_receiver #(.CPB(CPB)) dut (
    .C(C), .R(R), .D(D), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 C = ~C;

  always @(posedge C) cyc <= cyc + 1;

  // Record every valid pulse with the index of the edge that produced it.
  always @(negedge C) begin
    if (valid === 1'b1) begin
      obs_t.push_back(cyc);
      obs_d.push_back(data);
      obs_p.push_back(parity_err);
      obs_f.push_back(frame_err);
    end
  end

  // Reference: parity error when total count of ones (data + parity bit) is odd.
  function automatic logic ref_perr(input logic [7:0] b, input logic pb);
    return (($countones(b) + int'(pb)) % 2) != 0;
  endfunction

  // Called #1 after an edge; each bit is held for CPB edges.
  task automatic drive_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      D = f[i];
      repeat (CPB) @(posedge C);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pb, input logic sb,
                            output int t0);
    t0 = cyc + 1;
    drive_bits({sb, pb, b, 1'b0}, 11);
  endtask

  task automatic idle(input int n);
    D = 1'b1;
    repeat (n) begin
      @(posedge C);
      #1;
    end
  endtask

  task automatic test_reset();
    R = 1'b1;
    D = 1'b1;
    repeat (3) @(posedge C);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    R = 1'b0;
    idle(2);
  endtask

  task automatic test_frame(input string name, input logic [7:0] b, input logic pb);
    int t0;
    int n0;
    n0 = obs_t.size();
    send_frame(b, pb, 1'b1, t0);
    idle(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %b want 0", name, busy); end
    idle(3);
    checks++;
    if (obs_t.size() != n0 + 1) begin
      errors++; $display("FAIL %s_count got %0d want 1", name, obs_t.size() - n0);
    end else begin
      checks++; if (obs_t[n0] != t0 + LAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, obs_t[n0] - t0, LAT); end
      checks++; if (obs_d[n0] !== b) begin errors++; $display("FAIL %s_data got %h want %h", name, obs_d[n0], b); end
      checks++; if (obs_p[n0] !== ref_perr(b, pb)) begin errors++; $display("FAIL %s_perr got %b want %b", name, obs_p[n0], ref_perr(b, pb)); end
      checks++; if (obs_f[n0] !== 1'b0) begin errors++; $display("FAIL %s_ferr got %b want 0", name, obs_f[n0]); end
    end
  endtask

  task automatic test_false_start();
    int n0;
    int nbusy;
    logic [7:0] d0;
    n0 = obs_t.size();
    d0 = data;
    nbusy = 0;
    D = 1'b0;
    @(posedge C);
    #1;
    D = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (busy === 1'b1) nbusy++;
      @(posedge C);
      #1;
    end
    checks++; if (nbusy != 2) begin errors++; $display("FAIL false_start_busy got %0d want 2", nbusy); end
    checks++; if (obs_t.size() != n0) begin errors++; $display("FAIL false_start_valid got %0d want 0", obs_t.size() - n0); end
    checks++; if (data !== d0) begin errors++; $display("FAIL false_start_data got %h want %h", data, d0); end
  endtask

  task automatic test_frame_err();
    int t0;
    int n0;
    int nlow;
    n0 = obs_t.size();
    send_frame(8'h3C, ^8'h3C, 1'b0, t0);
    nlow = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1) nlow++;
      @(posedge C);
      #1;
    end
    checks++; if (nlow != 0) begin errors++; $display("FAIL ferr_busy_hold got %0d idle cycles want 0", nlow); end
    idle(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", busy); end
    idle(50);
    checks++;
    if (obs_t.size() != n0 + 1) begin
      errors++; $display("FAIL ferr_count got %0d want 1", obs_t.size() - n0);
    end else begin
      checks++; if (obs_t[n0] != t0 + LAT) begin errors++; $display("FAIL ferr_latency got %0d want %0d", obs_t[n0] - t0, LAT); end
      checks++; if (obs_d[n0] !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h want 3c", obs_d[n0]); end
      checks++; if (obs_f[n0] !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", obs_f[n0]); end
      checks++; if (obs_p[n0] !== 1'b0) begin errors++; $display("FAIL ferr_perr got %b want 0", obs_p[n0]); end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    n0 = obs_t.size();
    drive_bits({1'b1, ^8'h5A, 8'h5A, 1'b0}, 5);
    D = 1'b1 ^ 8'h5A >> 4 & 1'b1 ? 1'b1 : 1'b0;
    D = 1'b1;
    D = (8'h5A >> 4) & 8'h01 ? 1'b1 : 1'b0;
    repeat (2) @(posedge C);
    #1;
    R = 1'b1;
    D = 1'b1;
    @(posedge C);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midreset_data got %h want 00", data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midreset_ferr got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL midreset_perr got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL midreset_busy_valid got %b%b want 00", busy, valid); end
    R = 1'b0;
    idle(60);
    checks++; if (obs_t.size() != n0) begin errors++; $display("FAIL midreset_stray_valid got %0d want 0", obs_t.size() - n0); end
    test_frame("after_reset", 8'h5A, ^8'h5A);
  endtask

  task automatic test_back_to_back();
    int t0a;
    int t0b;
    int n0;
    n0 = obs_t.size();
    send_frame(8'h12, ^8'h12, 1'b1, t0a);
    send_frame(8'h34, ^8'h34, 1'b1, t0b);
    idle(4);
    checks++;
    if (obs_t.size() != n0 + 2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", obs_t.size() - n0);
    end else begin
      checks++; if (obs_t[n0 + 1] - obs_t[n0] != 11 * CPB) begin errors++; $display("FAIL b2b_gap got %0d want %0d", obs_t[n0 + 1] - obs_t[n0], 11 * CPB); end
      checks++; if (obs_d[n0] !== 8'h12 || obs_d[n0 + 1] !== 8'h34) begin errors++; $display("FAIL b2b_data got %h %h want 12 34", obs_d[n0], obs_d[n0 + 1]); end
      checks++; if ((obs_p[n0] | obs_p[n0 + 1] | obs_f[n0] | obs_f[n0 + 1]) !== 1'b0) begin errors++; $display("FAIL b2b_flags got %b%b%b%b want 0000", obs_p[n0], obs_p[n0 + 1], obs_f[n0], obs_f[n0 + 1]); end
    end
  endtask

  task automatic test_random();
    int         exp_t[$];
    logic [7:0] exp_d[$];
    logic       exp_p[$];
    logic       exp_f[$];
    int         n0;
    int         t0;
    logic [7:0] b;
    logic       pb;
    logic       sb;
    logic       prev_bad;
    int         bad;
    n0 = obs_t.size();
    prev_bad = 1'b0;
    for (int k = 0; k < 24; k++) begin
      b  = 8'($urandom);
      pb = ($countones(b) % 2 != 0) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) != 0);
      idle(prev_bad ? $urandom_range(1, 3) : $urandom_range(0, 3));
      send_frame(b, pb, sb, t0);
      exp_t.push_back(t0 + LAT);
      exp_d.push_back(b);
      exp_p.push_back(ref_perr(b, pb));
      exp_f.push_back(!sb);
      prev_bad = !sb;
    end
    idle(4);
    checks++;
    if (obs_t.size() - n0 != exp_t.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", obs_t.size() - n0, exp_t.size());
    end else begin
      bad = 0;
      for (int k = 0; k < exp_t.size(); k++) begin
        if (obs_t[n0 + k] != exp_t[k] || obs_d[n0 + k] !== exp_d[k] ||
            obs_p[n0 + k] !== exp_p[k] || obs_f[n0 + k] !== exp_f[k]) begin
          bad++;
          $display("FAIL rand_frame%0d got t%0d d%h p%b f%b want t%0d d%h p%b f%b", k,
                   obs_t[n0 + k], obs_d[n0 + k], obs_p[n0 + k], obs_f[n0 + k],
                   exp_t[k], exp_d[k], exp_p[k], exp_f[k]);
        end
      end
      checks++; if (bad != 0) begin errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_frame("basic_a5", 8'hA5, 1'b0);
    test_false_start();
    test_frame("parity_01", 8'h01, 1'b0);
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
